serial_sample_rx: RTL and testbench

SERIAL_SAMPLE_RX -- requirements
Module: serial_sample_rx

---
 rtl/serial_sample_rx_pkg.sv | 25 ++
 rtl/serial_sample_rx_sync.sv | 25 ++
 rtl/serial_sample_rx.sv | 140 ++++++++++++++
 tb/tb_serial_sample_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sample_rx_pkg.sv
// Shared definitions for the serial sample link (receiver and transmitter).
// Frame: start 0, 8 data bits LSB first, 3 stop bits 1.
package serial_sample_rx_pkg;

    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 3;
    localparam int FRAME_BITS = 12;
    localparam int SAMPLE_W   = 12;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // Serialized frame, bit 0 goes on the line first.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [DATA_BITS-1:0] b
    );
        return {{STOP_BITS{1'b1}}, b, 1'b0};
    endfunction

endpackage

// File: rtl/serial_sample_rx_sync.sv
// Multi-flop synchronizer for the asynchronous rx line.
// Flops reset to 1 so a reset never looks like a start bit.
module rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] ff;

    // Shift rx through the chain; the last flop is the clean copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '1;
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = ff[SYNC_STAGES-1];

endmodule

// File: rtl/serial_sample_rx.sv
// Serial byte receiver producing a 12-bit DAC sample.
// Mid-bit sampling FSM with good/error frame counters.
module serial_sample_rx
    import serial_sample_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic [SAMPLE_W-1:0]  sample_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic [15:0]          good_cnt,
    output logic [15:0]          err_cnt
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic                 rx_s;
    rx_state_t            state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [2:0]           idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 good_hit, err_hit;
    logic                 good_q, err_q;

    rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s)
    );

    // FSM state, bit timer, bit index and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shift  <= '0;
            good_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            shift  <= shift_n;
            good_q <= good_hit;
            err_q  <= err_hit;
        end
    end

    // Next-state logic; stop-bit verdicts are flagged for the output stage.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        idx_n    = idx;
        shift_n  = shift;
        good_hit = 1'b0;
        err_hit  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) begin
                    state_n = START;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift[DATA_BITS-1:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        good_hit = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        err_hit = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_n = '0;
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Output stage: pulses, held byte and wrapping frame counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            good_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            data_valid <= good_q;
            frame_err  <= err_q;
            if (good_q) begin
                data_out <= shift;
                good_cnt <= good_cnt + 16'd1;
            end
            if (err_q) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    assign sample_out = {data_out, {(SAMPLE_W - DATA_BITS){1'b0}}};

endmodule

// File: tb/tb_serial_sample_rx.sv
// Scoreboard bench for serial_sample_rx.
// Stimulus pushes expected pulses; a negedge monitor pops and checks.
module tb_serial_sample_rx;
    import serial_sample_rx_pkg::*;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 1 + CPB / 2 + 9 * CPB;

    typedef struct {
        bit          is_err;
        logic [7:0]  data;
        logic [15:0] cnt;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [7:0]  data_out;
    logic [11:0] sample_out;
    logic        data_valid;
    logic        frame_err;
    logic [15:0] good_cnt;
    logic [15:0] err_cnt;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [15:0] exp_good = 0;
    logic [15:0] exp_err = 0;
    logic [7:0]  exp_data = 0;

    serial_sample_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .sample_out (sample_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .good_cnt   (good_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_bits(input logic [11:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rx = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_good(input logic [7:0] b, input bit chk_lat);
        exp_t e;
        exp_good = exp_good + 16'd1;
        exp_data = b;
        e.is_err = 1'b0;
        e.data   = b;
        e.cnt    = exp_good;
        e.lat    = chk_lat ? cyc + 1 + LAT : -1;
        sb.push_back(e);
        send_bits(build_frame(b), 12);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d pulses missing, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " data_out"}, 32'(data_out), 32'h0);
        check({tag, " sample_out"}, 32'(sample_out), 32'h0);
        check({tag, " data_valid"}, 32'(data_valid), 32'h0);
        check({tag, " frame_err"}, 32'(frame_err), 32'h0);
        check({tag, " good_cnt"}, 32'(good_cnt), 32'h0);
        check({tag, " err_cnt"}, 32'(err_cnt), 32'h0);
        check({tag, " state"}, 32'(dut.state), 32'(IDLE));
    endtask

    // Monitor: pop and compare on every output pulse.
    initial begin
        bit   prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (data_valid && frame_err) begin
                check("both_pulses", 32'h1, 32'h0);
            end
            if (data_valid || frame_err) begin
                if (prev) check("pulse_width", 32'h2, 32'h1);
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {data_valid, frame_err}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("kind_err", 32'(frame_err), 32'(e.is_err));
                    check("data_out", 32'(data_out), 32'(e.data));
                    check("sample_out", 32'(sample_out), {e.data, 4'h0});
                    if (e.is_err) check("err_cnt", 32'(err_cnt), 32'(e.cnt));
                    else check("good_cnt", 32'(good_cnt), 32'(e.cnt));
                    if (e.lat >= 0) check("latency_cyc", cyc, e.lat);
                end
            end
            prev = data_valid || frame_err;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (SYNC + 4) @(negedge clk);

        // Single frame with latency check.
        send_good(8'hA5, 1'b1);
        drain();

        // Back-to-back frames, no idle gap.
        send_good(8'h00, 1'b0);
        send_good(8'hFF, 1'b0);
        send_good(8'h3C, 1'b0);
        drain();

        // Short glitch is rejected.
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch good_cnt", 32'(good_cnt), 32'(exp_good));
        check("glitch err_cnt", 32'(err_cnt), 32'(exp_err));
        check("glitch state", 32'(dut.state), 32'(IDLE));

        // Bad first stop bit, line held low.
        exp_err = exp_err + 16'd1;
        e.is_err = 1'b1;
        e.data   = exp_data;
        e.cnt    = exp_err;
        e.lat    = -1;
        sb.push_back(e);
        send_bits(build_frame(8'h5A), 9);
        rx = 1'b0;
        repeat (35) @(negedge clk);
        check("err state low", 32'(dut.state), 32'(WAIT_HIGH));
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("err state high", 32'(dut.state), 32'(IDLE));
        drain();
        send_good(8'h81, 1'b0);
        drain();

        // Reset in the middle of the 4th data bit.
        send_bits(build_frame(8'hC3), 4);
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        check_reset_outputs("midrst");
        exp_good = 0;
        exp_err  = 0;
        exp_data = 0;
        repeat (14 * CPB) @(negedge clk);
        check("midrst quiet good", 32'(good_cnt), 32'h0);
        send_good(8'h42, 1'b0);
        drain();

        // Good counter wraps.
        force dut.good_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.good_cnt;
        @(negedge clk);
        exp_good = 16'hFFFF;
        send_good(8'h99, 1'b0);
        drain();
        check("wrap good_cnt", 32'(good_cnt), 32'h0);

        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
